// File: rtl/juego_dados.sv
// Two-player dice game core: roll on hold, lock on release,
// resolve the round, keep win counts and scan display anodes.
module juego_dados #(
  parameter int SCAN_DIV   = 16,
  parameter int CONTEO_MAX = 15
) (
  input  logic       clk_pi,
  input  logic       rst_pi,
  input  logic [1:0] lanzar_pi,
  output logic [1:0] ultimo_ganador_po,
  output logic [7:0] control_anodos_po,
  output logic [5:0] dados_po,
  output logic [7:0] conteos_po
);

  localparam int LP_PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [LP_PW-1:0] LP_PMAX = LP_PW'(SCAN_DIV - 1);
  localparam logic [3:0] LP_CMAX = 4'(CONTEO_MAX);

  logic [1:0]       r_lanzar_q;
  logic [1:0]       r_listo;
  logic [2:0]       r_dado0;
  logic [2:0]       r_dado1;
  logic [3:0]       r_conteo0;
  logic [3:0]       r_conteo1;
  logic [1:0]       r_ganador;
  logic [LP_PW-1:0] r_pre;
  logic [7:0]       r_anodos;

  logic [1:0] w_roll;
  logic [1:0] w_rel;
  logic       w_res;
  logic       w_gana0;
  logic       w_gana1;
  logic [2:0] w_next0;
  logic [2:0] w_next1;

  // Die sequence 1..6; blank or illegal values restart at 1.
  function automatic logic [2:0] f_next(input logic [2:0] d);
    logic [2:0] n;
    n = 3'd1;
    if (d >= 3'd1 && d <= 3'd5) n = d + 3'd1;
    return n;
  endfunction

  assign w_roll  = lanzar_pi & ~r_listo;
  assign w_rel   = r_lanzar_q & ~lanzar_pi & ~r_listo;
  assign w_res   = &r_listo;
  assign w_gana0 = r_dado0 > r_dado1;
  assign w_gana1 = r_dado1 > r_dado0;
  assign w_next0 = f_next(r_dado0);
  assign w_next1 = f_next(r_dado1);

  // Previous button level, for release edge detection.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) r_lanzar_q <= 2'b00;
    else        r_lanzar_q <= lanzar_pi;
  end

  // Dice advance while the button is held and the roll is open.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_dado0 <= 3'd0;
      r_dado1 <= 3'd0;
    end else begin
      if (w_roll[0]) r_dado0 <= w_next0;
      if (w_roll[1]) r_dado1 <= w_next1;
    end
  end

  // Roll-complete flags: set on release, cleared when the round resolves.
  always_ff @(posedge clk_pi) begin
    if (rst_pi)     r_listo <= 2'b00;
    else if (w_res) r_listo <= 2'b00;
    else            r_listo <= r_listo | w_rel;
  end

  // Round result and saturating win counters.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_ganador <= 2'b00;
      r_conteo0 <= 4'd0;
      r_conteo1 <= 4'd0;
    end else if (w_res) begin
      unique case (1'b1)
        w_gana0: begin
          r_ganador <= 2'b01;
          if (r_conteo0 < LP_CMAX) r_conteo0 <= r_conteo0 + 4'd1;
        end
        w_gana1: begin
          r_ganador <= 2'b10;
          if (r_conteo1 < LP_CMAX) r_conteo1 <= r_conteo1 + 4'd1;
        end
        default: r_ganador <= 2'b11;
      endcase
    end
  end

  // Free-running prescaler stepping the active-low anode rotation.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      r_pre    <= '0;
      r_anodos <= 8'hFE;
    end else if (r_pre == LP_PMAX) begin
      r_pre    <= '0;
      r_anodos <= {r_anodos[6:0], r_anodos[7]};
    end else begin
      r_pre    <= r_pre + LP_PW'(1);
    end
  end

  assign ultimo_ganador_po = r_ganador;
  assign control_anodos_po = r_anodos;
  assign dados_po          = {r_dado1, r_dado0};
  assign conteos_po        = {r_conteo1, r_conteo0};

endmodule

// File: tb/tb_juego_dados.sv
// Bench for juego_dados: spec model feeds a result scoreboard,
// scenario tasks check reset, rounds, lock-out, saturation, scan.
module tb_juego_dados;

  localparam int SD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lanz = 2'b00;
  logic [1:0] gan;
  logic [7:0] an;
  logic [5:0] dados;
  logic [7:0] cnt;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] c;
    logic [5:0] d;
  } exp_t;

  exp_t sb[$];

  logic [2:0] m_d0, m_d1;
  logic [3:0] m_c0, m_c1;
  logic [1:0] m_listo, m_q, m_gan;

  juego_dados #(.SCAN_DIV(SD), .CONTEO_MAX(15)) dut (
    .clk_pi(clk),
    .rst_pi(rst),
    .lanzar_pi(lanz),
    .ultimo_ganador_po(gan),
    .control_anodos_po(an),
    .dados_po(dados),
    .conteos_po(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_next(input logic [2:0] d);
    if (d == 3'd0 || d == 3'd6 || d == 3'd7) return 3'd1;
    return d + 3'd1;
  endfunction

  // One clock: drive buttons, update the model at the edge,
  // return on the falling edge where outputs are sampled.
  task automatic tick(input logic [1:0] l);
    logic [2:0] n0, n1;
    logic [1:0] rel;
    exp_t e;
    lanz = l;
    @(posedge clk);
    if (rst) begin
      m_d0 = 0; m_d1 = 0; m_c0 = 0; m_c1 = 0;
      m_listo = 0; m_q = 0; m_gan = 0;
      sb.delete();
    end else begin
      n0 = (l[0] && !m_listo[0]) ? m_next(m_d0) : m_d0;
      n1 = (l[1] && !m_listo[1]) ? m_next(m_d1) : m_d1;
      rel = m_q & ~l & ~m_listo;
      if (m_listo == 2'b11) begin
        if (m_d0 > m_d1) begin
          m_gan = 2'b01;
          if (m_c0 != 4'hF) m_c0 = m_c0 + 1;
        end else if (m_d1 > m_d0) begin
          m_gan = 2'b10;
          if (m_c1 != 4'hF) m_c1 = m_c1 + 1;
        end else begin
          m_gan = 2'b11;
        end
        m_listo = 2'b00;
        e.g = m_gan; e.c = {m_c1, m_c0}; e.d = {n1, n0};
        sb.push_back(e);
      end else begin
        m_listo = m_listo | rel;
      end
      m_d0 = n0; m_d1 = n1; m_q = l;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) tick(2'b00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (dados !== 6'd0) begin bad++; $display("FAIL rst_dados got=%h exp=00", dados); end
    total++; if (cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=00", cnt); end
    total++; if (gan !== 2'b00) begin bad++; $display("FAIL rst_gan got=%b exp=00", gan); end
    total++; if (an !== 8'hFE) begin bad++; $display("FAIL rst_an got=%h exp=FE", an); end
  endtask

  task automatic test_p0_win();
    exp_t e;
    repeat (3) tick(2'b01);
    tick(2'b00);
    repeat (2) tick(2'b10);
    tick(2'b00);
    total++; if (gan !== 2'b00) begin bad++; $display("FAIL p0_latency got=%b exp=00", gan); end
    tick(2'b00);
    total++; if (dados !== {3'd2, 3'd3}) begin bad++; $display("FAIL p0_dados got=%h exp=13", dados); end
    total++; if (gan !== 2'b01) begin bad++; $display("FAIL p0_gan got=%b exp=01", gan); end
    total++; if (cnt !== 8'h01) begin bad++; $display("FAIL p0_cnt got=%h exp=01", cnt); end
    total++;
    if (sb.size() != 1) begin bad++; $display("FAIL p0_sb_size got=%0d exp=1", sb.size()); end
    else begin
      e = sb.pop_front();
      if ({gan, cnt, dados} !== e) begin bad++; $display("FAIL p0_sb got=%h exp=%h", {gan, cnt, dados}, e); end
    end
  endtask

  task automatic test_tie_wrap();
    exp_t e;
    apply_reset();
    repeat (7) tick(2'b11);
    tick(2'b00);
    tick(2'b00);
    total++; if (dados !== {3'd1, 3'd1}) begin bad++; $display("FAIL tie_dados got=%h exp=09", dados); end
    total++; if (gan !== 2'b11) begin bad++; $display("FAIL tie_gan got=%b exp=11", gan); end
    total++; if (cnt !== 8'h00) begin bad++; $display("FAIL tie_cnt got=%h exp=00", cnt); end
    total++;
    if (sb.size() != 1) begin bad++; $display("FAIL tie_sb_size got=%0d exp=1", sb.size()); end
    else begin
      e = sb.pop_front();
      if ({gan, cnt, dados} !== e) begin bad++; $display("FAIL tie_sb got=%h exp=%h", {gan, cnt, dados}, e); end
    end
  endtask

  task automatic test_lockout();
    exp_t e;
    apply_reset();
    repeat (4) tick(2'b01);
    tick(2'b00);
    repeat (3) tick(2'b01);
    total++; if (dados[2:0] !== 3'd4) begin bad++; $display("FAIL lock_d0 got=%0d exp=4", dados[2:0]); end
    total++; if (gan !== 2'b00) begin bad++; $display("FAIL lock_early got=%b exp=00", gan); end
    tick(2'b00);
    tick(2'b10);
    tick(2'b00);
    tick(2'b00);
    total++; if (dados !== {3'd1, 3'd4}) begin bad++; $display("FAIL lock_dados got=%h exp=0c", dados); end
    total++; if ({gan, cnt} !== {2'b01, 8'h01}) begin bad++; $display("FAIL lock_res got=%h exp=101", {gan, cnt}); end
    total++;
    if (sb.size() != 1) begin bad++; $display("FAIL lock_sb_size got=%0d exp=1", sb.size()); end
    else begin
      e = sb.pop_front();
      if ({gan, cnt, dados} !== e) begin bad++; $display("FAIL lock_sb got=%h exp=%h", {gan, cnt, dados}, e); end
    end
  endtask

  task automatic test_overlap();
    exp_t e;
    apply_reset();
    tick(2'b01);
    total++; if (dados !== {3'd0, 3'd1}) begin bad++; $display("FAIL ovl_first got=%h exp=01", dados); end
    repeat (15) tick(2'b11);
    total++; if (dados !== {3'd3, 3'd4}) begin bad++; $display("FAIL ovl_dados got=%h exp=1c", dados); end
    tick(2'b00);
    tick(2'b00);
    tick(2'b00);
    total++; if ({gan, cnt} !== {2'b01, 8'h01}) begin bad++; $display("FAIL ovl_res got=%h exp=101", {gan, cnt}); end
    total++;
    if (sb.size() != 1) begin bad++; $display("FAIL ovl_sb_size got=%0d exp=1", sb.size()); end
    else begin
      e = sb.pop_front();
      if ({gan, cnt, dados} !== e) begin bad++; $display("FAIL ovl_sb got=%h exp=%h", {gan, cnt, dados}, e); end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [3:0] w;
    apply_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) begin
        tick(2'b11);
        tick(2'b10);
      end else begin
        repeat (6) tick(2'b11);
      end
      tick(2'b00);
      tick(2'b00);
      w = (k < 15) ? 4'(k) : 4'hF;
      total++;
      if ({gan, cnt} !== {2'b10, w, 4'h0}) begin
        bad++; $display("FAIL sat_round%0d got=%h exp=%h", k, {gan, cnt}, {2'b10, w, 4'h0});
      end
      total++;
      if (sb.size() != 1) begin bad++; $display("FAIL sat_sb_size%0d got=%0d exp=1", k, sb.size()); end
      else begin
        e = sb.pop_front();
        if ({gan, cnt, dados} !== e) begin bad++; $display("FAIL sat_sb%0d got=%h exp=%h", k, {gan, cnt, dados}, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) tick(2'b01);
    tick(2'b00);
    apply_reset();
    total++; if ({gan, cnt, dados} !== 16'h0) begin bad++; $display("FAIL mid_rst got=%h exp=0000", {gan, cnt, dados}); end
    tick(2'b10);
    repeat (3) tick(2'b00);
    total++; if (gan !== 2'b00) begin bad++; $display("FAIL mid_stale got=%b exp=00", gan); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL mid_sb got=%0d exp=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_scan();
    logic [7:0] seq [0:8];
    seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      repeat (SD - 1) tick(2'b00);
      total++; if (an !== seq[k]) begin bad++; $display("FAIL scan_hold%0d got=%h exp=%h", k, an, seq[k]); end
      tick(2'b00);
      total++; if (an !== seq[k+1]) begin bad++; $display("FAIL scan_step%0d got=%h exp=%h", k, an, seq[k+1]); end
    end
  endtask

  initial begin
    test_reset();
    test_p0_win();
    test_tie_wrap();
    test_lockout();
    test_overlap();
    test_saturation();
    test_reset_mid();
    test_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
